// File: rtl/ifetch_stage.sv
// Purpose: instruction fetch stage feeding decode. Issues sequential word fetches, pairs in-order responses with their PCs, and buffers them.
// Latency: a response arriving in cycle N is presented to decode in cycle N+1 when the buffer is empty and decode is not stalled.
// Backpressure: decode_stall holds the outputs; requests stop once in-flight plus buffered entries reach FIFO_DEPTH. Optional macro IFETCH_PERF_COUNTERS_EN adds perf counters.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_v,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_v,
    input  logic [31:0] imem_resp_data,
    input  logic        decode_stall,
    input  logic        redirect_v,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifetch_decode_pc,
    output logic [31:0] ifetch_decode_instruction,
    output logic        ifetch_decode_v
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall
`endif
);

    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {e_fetch, e_flush} state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_resp_pc;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_drop_cnt;

    logic [31:0]    r_fifo_pc  [FIFO_DEPTH];
    logic [31:0]    r_fifo_ins [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic [31:0]    r_out_pc;
    logic [31:0]    r_out_ins;
    logic           r_out_v;

    logic [CW:0]    w_inflight;
    logic           w_req_v;
    logic           w_req_hs;
    logic           w_resp_take;
    logic           w_pop;
    logic           w_bypass;
    logic           w_push;
    logic [CW-1:0]  w_drop_next;
    logic [31:0]    w_redirect_pc;

    // In-flight plus buffered entries bound the request stream so a push always finds space
    assign w_inflight    = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_v       = !rst && (r_state == e_fetch) && !redirect_v &&
                           (w_inflight < (CW+1)'(FIFO_DEPTH));
    assign w_req_hs      = w_req_v && imem_req_ready;
    // Responses are only kept in e_fetch; anything arriving with a redirect is wrong-path
    assign w_resp_take   = imem_resp_v && (r_state == e_fetch) && !redirect_v;
    assign w_pop         = !redirect_v && !decode_stall && (r_count != '0);
    assign w_bypass      = !redirect_v && !decode_stall && (r_count == '0) && w_resp_take;
    assign w_push        = w_resp_take && !w_bypass;
    assign w_drop_next   = r_outstanding - CW'(imem_resp_v);
    assign w_redirect_pc = redirect_pc & ~32'h3;

    assign imem_req_v                = w_req_v;
    assign imem_req_addr             = r_fetch_pc;
    assign ifetch_decode_pc          = r_out_pc;
    assign ifetch_decode_instruction = r_out_ins;
    assign ifetch_decode_v           = r_out_v;

    // Fetch FSM: PC generation, outstanding tracking and wrong-path drop counting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= e_fetch;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_v) begin
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_outstanding <= w_drop_next;
            r_drop_cnt    <= w_drop_next;
            r_state       <= (w_drop_next != '0) ? e_flush : e_fetch;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_hs) - CW'(imem_resp_v);
            if (w_req_hs) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_resp_take) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if ((r_state == e_flush) && imem_resp_v) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
                if (r_drop_cnt == CW'(1)) begin
                    r_state <= e_fetch;
                end
            end
        end
    end

    // FIFO pointers and occupancy; a redirect discards all buffered entries
    always_ff @(posedge clk) begin
        if (rst || redirect_v) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage needs no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]  <= r_resp_pc;
            r_fifo_ins[r_wr_ptr] <= imem_resp_data;
        end
    end

    // Decode-facing register: redirect forces a bubble even under stall, else hold/pop/bypass/bubble
    always_ff @(posedge clk) begin
        if (rst || redirect_v) begin
            r_out_pc  <= '0;
            r_out_ins <= NOP;
            r_out_v   <= 1'b0;
        end else if (!decode_stall) begin
            if (r_count != '0) begin
                r_out_pc  <= r_fifo_pc[r_rd_ptr];
                r_out_ins <= r_fifo_ins[r_rd_ptr];
                r_out_v   <= 1'b1;
            end else if (w_bypass) begin
                r_out_pc  <= r_resp_pc;
                r_out_ins <= imem_resp_data;
                r_out_v   <= 1'b1;
            end else begin
                r_out_pc  <= '0;
                r_out_ins <= NOP;
                r_out_v   <= 1'b0;
            end
        end
    end

`ifdef IFETCH_PERF_COUNTERS_EN
    // Event counters: consumed instructions, discarded wrong-path work, stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (r_out_v && !decode_stall) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_v) begin
                perf_dropped <= perf_dropped + 32'(r_count) + 32'(imem_resp_v);
            end else if ((r_state == e_flush) && imem_resp_v) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (decode_stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: stream, stall, memory not ready, redirect with drops, redirect under stall.
// Memory model: in-order responses with a configurable fixed latency of 1 or 2 cycles.
// Build with IFETCH_PERF_COUNTERS_EN defined to also cover the perf counters.
module tb_ifetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_v;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_v;
    logic [31:0] imem_resp_data;
    logic        decode_stall;
    logic        redirect_v;
    logic [31:0] redirect_pc;
    logic [31:0] ifetch_decode_pc;
    logic [31:0] ifetch_decode_instruction;
    logic        ifetch_decode_v;
`ifdef IFETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    int          total = 0;
    int          bad   = 0;
    int          ovf_cnt = 0;
    int          lat = 1;
    logic        pv [4];
    logic [31:0] pa [4];
    logic [31:0] m_fetched = 0;
    logic [31:0] m_stall = 0;

    ifetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .imem_req_v                (imem_req_v),
        .imem_req_addr             (imem_req_addr),
        .imem_req_ready            (imem_req_ready),
        .imem_resp_v               (imem_resp_v),
        .imem_resp_data            (imem_resp_data),
        .decode_stall              (decode_stall),
        .redirect_v                (redirect_v),
        .redirect_pc               (redirect_pc),
        .ifetch_decode_pc          (ifetch_decode_pc),
        .ifetch_decode_instruction (ifetch_decode_instruction),
        .ifetch_decode_v           (ifetch_decode_v)
`ifdef IFETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched              (perf_fetched),
        .perf_dropped              (perf_dropped),
        .perf_stall                (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Instruction word stored at an address: addi x(n),x0,n with n = word index + 1
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] n;
        n = (a >> 2) + 32'd1;
        return {n[11:0], 5'd0, 3'd0, n[4:0], 7'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
        check({tag, "_v"},   {31'd0, ifetch_decode_v}, {31'd0, v});
        check({tag, "_pc"},  ifetch_decode_pc, pc);
        check({tag, "_ins"}, ifetch_decode_instruction, ins);
    endtask

    // One clock: sample the request handshake before the edge, then drive the memory response after it
    task automatic tick();
        logic        hs;
        logic [31:0] ha;
        @(negedge clk);
        hs = imem_req_v && imem_req_ready;
        ha = imem_req_addr;
        if (dut.w_push && (int'(dut.r_count) == DEPTH)) ovf_cnt++;
        if (rst) begin
            m_fetched = 0;
            m_stall   = 0;
        end else begin
            if (ifetch_decode_v && !decode_stall) m_fetched = m_fetched + 1;
            if (decode_stall) m_stall = m_stall + 1;
        end
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = hs;
        pa[0] = ha;
        if (rst) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        end
        imem_resp_v    = pv[lat-1];
        imem_resp_data = pv[lat-1] ? word_at(pa[lat-1]) : 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = 32'h0;
        end
        rst = 1'b1; imem_req_ready = 1'b1; imem_resp_v = 1'b0; imem_resp_data = 32'h0;
        decode_stall = 1'b0; redirect_v = 1'b0; redirect_pc = 32'h0;

        // Reset and a 1-cycle-latency stream
        lat = 1;
        tick();
        check_out("reset", 32'h0, NOP, 1'b0);
        check("reset_req_v", {31'd0, imem_req_v}, 32'd0);
        rst = 1'b0;
        #1;
        check("first_req_v", {31'd0, imem_req_v}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        tick();
        check("c1_v", {31'd0, ifetch_decode_v}, 32'd0);
        tick();
        check_out("s0", 32'h0, 32'h0010_0093, 1'b1);
        tick();
        check_out("s1", 32'h4, 32'h0020_0113, 1'b1);
        tick();
        check_out("s2", 32'h8, word_at(32'h8), 1'b1);

        // Decode stall for three cycles: outputs frozen, requests capped
        decode_stall = 1'b1;
        tick();
        check_out("stall1", 32'h8, word_at(32'h8), 1'b1);
        check("stall1_req_v", {31'd0, imem_req_v}, 32'd0);
        tick();
        check_out("stall2", 32'h8, word_at(32'h8), 1'b1);
        check("stall2_req_v", {31'd0, imem_req_v}, 32'd0);
        tick();
        check_out("stall3", 32'h8, word_at(32'h8), 1'b1);
        decode_stall = 1'b0;
        tick();
        check_out("resume0", 32'hC, word_at(32'hC), 1'b1);
        check("resume_req_v", {31'd0, imem_req_v}, 32'd1);
        check("resume_req_addr", imem_req_addr, 32'h14);
        tick();
        check_out("resume1", 32'h10, word_at(32'h10), 1'b1);
        tick();
        check_out("resume2", 32'h14, word_at(32'h14), 1'b1);

        // Memory not ready for five cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("nr_req_v", {31'd0, imem_req_v}, 32'd1);
            check("nr_req_addr", imem_req_addr, 32'h0);
            check_out("nr_bubble", 32'h0, NOP, 1'b0);
        end
        imem_req_ready = 1'b1;
        tick();
        check("nr_wait_v", {31'd0, ifetch_decode_v}, 32'd0);
        tick();
        check_out("nr_first", 32'h0, 32'h0010_0093, 1'b1);
        tick();
        check_out("nr_second", 32'h4, 32'h0020_0113, 1'b1);

        // Redirect with two requests outstanding, 2-cycle latency memory
        rst = 1'b1;
        lat = 2;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("cap_req_v", {31'd0, imem_req_v}, 32'd0);
        redirect_v = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_v = 1'b0;
        check_out("redir_bubble", 32'h0, NOP, 1'b0);
        check("flush_req_v", {31'd0, imem_req_v}, 32'd0);
        tick();
        check("post_flush_req_v", {31'd0, imem_req_v}, 32'd1);
        check("post_flush_addr", imem_req_addr, 32'h100);
        tick();
        tick();
        check("redir_wait_v", {31'd0, ifetch_decode_v}, 32'd0);
        tick();
        check_out("redir_first", 32'h100, word_at(32'h100), 1'b1);
`ifdef IFETCH_PERF_COUNTERS_EN
        check("perf_dropped", perf_dropped, 32'd2);
        check("perf_fetched_a", perf_fetched, m_fetched);
`endif

        // Redirect together with a stall: bubble wins, target aligned down
        decode_stall = 1'b1;
        redirect_v = 1'b1;
        redirect_pc = 32'h203;
        tick();
        check_out("redir_stall", 32'h0, NOP, 1'b0);
        redirect_v = 1'b0;
        decode_stall = 1'b0;
        #1;
        check("redir_stall_req_v", {31'd0, imem_req_v}, 32'd1);
        check("redir_stall_addr", imem_req_addr, 32'h200);
        tick();
        tick();
        tick();
        check_out("redir_stall_first", 32'h200, word_at(32'h200), 1'b1);
        tick();
`ifdef IFETCH_PERF_COUNTERS_EN
        check("perf_fetched_b", perf_fetched, m_fetched);
        check("perf_stall", perf_stall, m_stall);
`endif

        check("fifo_overflow", ovf_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
